// File: rtl/disp_share_arbiter.sv
// disp_share_arbiter: shares one 4-digit seven-segment display driver between N_REQ requesters.
// Round-robin arbitration with a minimum ownership time and a blanking gap between owners.
//
// Optional feature: define DISP_ARB_LOCK_EN to add I_lock. While I_lock is high in OWN,
// preemption by other requesters is suppressed. Release on request drop still applies.
//
// Ports:
//   I_sys_clk        system clock
//   I_rst_n          asynchronous active-low reset
//   I_req            per-requester level request
//   I_disp_data_bus  requester k's 4 hex digits in bits [16k+15:16k]
//   I_lock           (DISP_ARB_LOCK_EN only) pin the current owner
//   O_gnt            registered one-hot grant
//   O_owner          index of the current or last owner
//   O_disp_en        display driver enable (high in OWN)
//   O_disp_data      registered display data
//   O_busy           high in OWN or BLANK
module disp_share_arbiter #(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned IDX_W        = 2,
   parameter int unsigned HOLD_W       = 24,
   parameter int unsigned MIN_HOLD     = 24'd5_000_000,
   parameter int unsigned BLANK_CYCLES = 24'd250_000
) (
   input  logic                 I_sys_clk,
   input  logic                 I_rst_n,
   input  logic [N_REQ-1:0]     I_req,
   input  logic [16*N_REQ-1:0]  I_disp_data_bus,
`ifdef DISP_ARB_LOCK_EN
   input  logic                 I_lock,
`endif
   output logic [N_REQ-1:0]     O_gnt,
   output logic [IDX_W-1:0]     O_owner,
   output logic                 O_disp_en,
   output logic [15:0]          O_disp_data,
   output logic                 O_busy
);

   // Configuration sanity, evaluated at elaboration.
   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("disp_share_arbiter: N_REQ must be in 2..8");
   end
   if (IDX_W != $clog2(N_REQ)) begin : g_bad_idx_w
      $error("disp_share_arbiter: IDX_W must equal clog2(N_REQ)");
   end
   if (MIN_HOLD < 1 || 64'(MIN_HOLD) >= (64'd1 << HOLD_W)) begin : g_bad_min_hold
      $error("disp_share_arbiter: MIN_HOLD must be >= 1 and fit in HOLD_W bits");
   end
   if (BLANK_CYCLES < 1 || 64'(BLANK_CYCLES) >= (64'd1 << HOLD_W)) begin : g_bad_blank
      $error("disp_share_arbiter: BLANK_CYCLES must be >= 1 and fit in HOLD_W bits");
   end

   localparam logic [HOLD_W-1:0] MinHold   = HOLD_W'(MIN_HOLD);
   localparam logic [HOLD_W-1:0] BlankLast = HOLD_W'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StOwn, StBlank} state_e;

   state_e              state_q, state_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [HOLD_W-1:0]   blank_q, blank_d;
   logic [15:0]         data_q, data_d;

   logic [15:0]         slice [N_REQ];
   logic [IDX_W-1:0]    winner;
   logic                found;
   logic                lock_off;
   logic                release_req;
   logic                preempt;

   for (genvar k = 0; k < N_REQ; k++) begin : g_slice
      assign slice[k] = I_disp_data_bus[16*k +: 16];
   end

`ifdef DISP_ARB_LOCK_EN
   assign lock_off = ~I_lock;
`else
   assign lock_off = 1'b1;
`endif

   // Round-robin search starting just after the last owner; the last owner itself is
   // visited last, so a preempted owner only wins when nobody else is asking.
   always_comb begin
      winner = owner_q;
      found  = 1'b0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         logic [IDX_W-1:0] cand;
         cand = IDX_W'((32'(owner_q) + k) % N_REQ);
         if (!found && I_req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign release_req = ~I_req[owner_q];
   // gnt_q is the owner's one-hot in OWN, so masking it leaves only the competitors.
   assign preempt     = (hold_q == MinHold) && (|(I_req & ~gnt_q)) && lock_off;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      hold_d  = hold_q;
      blank_d = blank_q;
      data_d  = data_q;
      case (state_q)
         StIdle: begin
            if (|I_req) begin
               state_d        = StOwn;
               gnt_d          = '0;
               gnt_d[winner]  = 1'b1;
               owner_d        = winner;
               hold_d         = '0;
            end
         end
         StOwn: begin
            data_d = slice[owner_q];
            if (release_req || preempt) begin
               state_d = StBlank;
               gnt_d   = '0;
               data_d  = '0;
               blank_d = '0;
            end else if (hold_q != MinHold) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         StBlank: begin
            if (blank_q == BlankLast) begin
               state_d = StIdle;
            end else begin
               blank_d = blank_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
            data_d  = '0;
         end
      endcase
   end

   always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         owner_q <= IDX_W'(N_REQ - 1);
         hold_q  <= '0;
         blank_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         blank_q <= blank_d;
         data_q  <= data_d;
      end
   end

   assign O_gnt       = gnt_q;
   assign O_owner     = owner_q;
   assign O_disp_en   = (state_q == StOwn);
   assign O_disp_data = data_q;
   assign O_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Self-checking bench for disp_share_arbiter (N_REQ=4, MIN_HOLD=8, BLANK_CYCLES=3).
// A cycle reference model predicts the output bundle at every rising edge; predictions are
// queued and compared 1 ns later. Directed checks cover the timing scenarios explicitly.
module tb_disp_share_arbiter;

   localparam int unsigned MinHold     = 8;
   localparam int unsigned BlankCycles = 3;
   localparam logic [31:0] RstPack     = 32'({4'b0000, 2'd3, 1'b0, 16'h0000, 1'b0});

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req   = '0;
   logic [63:0] bus   = '0;
   logic        lock  = 1'b0;

   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        en;
   logic [15:0] data;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   disp_share_arbiter #(
      .N_REQ        (4),
      .IDX_W        (2),
      .HOLD_W       (24),
      .MIN_HOLD     (24'd8),
      .BLANK_CYCLES (24'd3)
   ) u_dut (
      .I_sys_clk       (clk),
      .I_rst_n         (rst_n),
      .I_req           (req),
      .I_disp_data_bus (bus),
`ifdef DISP_ARB_LOCK_EN
      .I_lock          (lock),
`endif
      .O_gnt           (gnt),
      .O_owner         (owner),
      .O_disp_en       (en),
      .O_disp_data     (data),
      .O_busy          (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] obs_pack();
      return 32'({gnt, owner, en, data, busy});
   endfunction

   // ---------------- reference model ----------------
   int          m_state;   // 0 idle, 1 own, 2 blank
   logic [1:0]  m_owner;
   int          m_hold;
   int          m_blank;
   logic [3:0]  m_gnt;
   logic [15:0] m_data;
   logic [23:0] sb_q[$];

   task automatic model_reset();
      m_state = 0;
      m_owner = 2'd3;
      m_hold  = 0;
      m_blank = 0;
      m_gnt   = '0;
      m_data  = '0;
   endtask

   task automatic model_step(input logic [3:0] r, input logic [63:0] b, input logic lk);
      logic [7:0] dbl;
      logic [3:0] rot;
      int         j;
      int         o;
      o = int'(m_owner);
      case (m_state)
         0: begin
            if (r != 4'b0) begin
               // rotate so the candidate right after the owner lands in bit 0
               dbl = {r, r};
               rot = 4'(dbl >> (o + 1));
               j = 0;
               while (!rot[0]) begin
                  rot = rot >> 1;
                  j++;
               end
               m_owner = 2'((o + 1 + j) % 4);
               m_gnt   = 4'b0001 << m_owner;
               m_hold  = 0;
               m_state = 1;
            end
         end
         1: begin
            m_data = b[16*o +: 16];
            if (!r[m_owner] || (m_hold == MinHold && (r & ~m_gnt) != 4'b0 && !lk)) begin
               m_state = 2;
               m_blank = 0;
               m_gnt   = '0;
               m_data  = '0;
            end else if (m_hold < MinHold) begin
               m_hold++;
            end
         end
         default: begin
            if (m_blank == BlankCycles - 1) m_state = 0;
            else m_blank++;
         end
      endcase
   endtask

   function automatic logic [23:0] model_pack();
      return {m_gnt, m_owner, 1'(m_state == 1), m_data, 1'(m_state != 0)};
   endfunction

   // Scoreboard: predict at the edge, compare shortly after.
   initial begin
      logic [23:0] e;
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            model_reset();
            sb_q.delete();
         end else begin
            model_step(req, bus, lock);
            sb_q.push_back(model_pack());
            #1;
            if (sb_q.size() == 0) begin
               check_eq("sb_empty", 32'(1), 32'(0));
            end else begin
               e = sb_q.pop_front();
               check_eq("sb_cycle", obs_pack(), 32'(e));
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_gnt(input logic [3:0] want, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (gnt != 4'b0) seen = 1'b1;
         else @(negedge clk);
      end
      check_eq(tag, 32'(gnt), 32'(want));
   endtask

   task automatic run_len_en(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         if (!en) break;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_len_blank(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         if (!(busy && !en)) break;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check_eq(tag, 32'(busy), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int own_len;
      int gap_len;

      // Reset values, then async reset mid-OWN, then first grant.
      repeat (2) @(negedge clk);
      check_eq("rst_init", obs_pack(), RstPack);
      rst_n = 1'b1;
      req   = 4'b0001;
      bus[15:0] = 16'h0A0A;
      repeat (4) @(negedge clk);
      check_eq("t1_own_data", 32'({gnt, en, data}), 32'({4'b0001, 1'b1, 16'h0A0A}));
      #2 rst_n = 1'b0;
      #1 check_eq("t1_async_rst", obs_pack(), RstPack);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b0101;
      #1 check_eq("t1_no_early_gnt", 32'(gnt), 32'(0));
      @(negedge clk);
      check_eq("t1_first_gnt", 32'({gnt, owner}), 32'({4'b0001, 2'd0}));
      req = 4'b0000;
      wait_idle("t1_idle");

      // Lone owner keeps the display; release gives exactly 3 blank cycles.
      bus[31:16] = 16'h1234;
      req = 4'b0010;
      @(negedge clk);
      check_eq("t2_gnt", 32'({gnt, owner}), 32'({4'b0010, 2'd1}));
      @(negedge clk);
      check_eq("t2_data", 32'(data), 32'h1234);
      repeat (100) @(negedge clk);
      check_eq("t2_hold", 32'({gnt, en, data}), 32'({4'b0010, 1'b1, 16'h1234}));
      req = 4'b0000;
      @(negedge clk);
      run_len_blank(gap_len);
      check_eq("t2_gap", 32'(gap_len), 32'(3));
      check_eq("t2_idle", 32'({busy, en}), 32'(0));

      // Rotation 0,1,2,3,0 from reset, OWN of 9 cycles, 3-cycle gaps.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(4'b0001 << (k % 4), "t3_order");
         if (k < 4) begin
            run_len_en(own_len);
            check_eq("t3_own_len", 32'(own_len), 32'(9));
            run_len_blank(gap_len);
            check_eq("t3_gap", 32'(gap_len), 32'(3));
         end
      end

      // Live data tracking for owner 2.
      bus[47:32] = 16'hABCD;
      req = 4'b0100;
      @(negedge clk);
      wait_gnt(4'b0100, "t4_gnt");
      @(negedge clk);
      check_eq("t4_data", 32'(data), 32'hABCD);
      bus[47:32] = 16'h00FF;
      #1 check_eq("t4_not_early", 32'(data), 32'hABCD);
      @(negedge clk);
      check_eq("t4_tracked", 32'(data), 32'h00FF);
      bus[15:0]  = 16'h5555;
      bus[63:48] = 16'h7777;
      @(negedge clk);
      check_eq("t4_other_slices", 32'(data), 32'h00FF);

      // Request raised during the 2nd blank cycle is only seen in IDLE.
      req = 4'b0001;
      @(negedge clk);
      wait_gnt(4'b0001, "t5_gnt0");
      req = 4'b0000;
      @(negedge clk);
      check_eq("t5_blank1", 32'({busy, en}), 32'(2'b10));
      @(negedge clk);
      req = 4'b1000;
      #1 check_eq("t5_blank2", 32'(gnt), 32'(0));
      @(negedge clk);
      check_eq("t5_blank3", 32'({gnt, busy}), 32'({4'b0000, 1'b1}));
      @(negedge clk);
      check_eq("t5_idle", 32'({gnt, busy}), 32'(0));
      @(negedge clk);
      check_eq("t5_gnt3", 32'({gnt, owner}), 32'({4'b1000, 2'd3}));

`ifdef DISP_ARB_LOCK_EN
      // Lock pins owner 0; dropping it preempts at once.
      req = 4'b0001;
      @(negedge clk);
      wait_gnt(4'b0001, "t6_gnt0");
      lock = 1'b1;
      req  = 4'b0011;
      repeat (60) @(negedge clk);
      check_eq("t6_locked", 32'({gnt, en}), 32'({4'b0001, 1'b1}));
      lock = 1'b0;
      @(negedge clk);
      check_eq("t6_release", 32'({busy, en}), 32'(2'b10));
      wait_gnt(4'b0010, "t6_gnt1");
`endif

      req = 4'b0000;
      repeat (10) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/disp_share_arbiter.md
Name: disp_share_arbiter

Overview:
- Shares the single 4-digit seven-segment display driver between N_REQ requesters, e.g. a counter, a UART monitor and a switch-echo source.
- Uses round-robin arbitration with a minimum ownership time, so each requester's digits stay visible long enough to read.
- Inserts a blanking gap between owners.
- Drives the display driver's enable and 16-bit hex data inputs directly.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the owner index; must equal clog2(N_REQ).
- HOLD_W, 24, width of the hold and blank counters.
- MIN_HOLD, 24'd5_000_000, minimum cycles an owner keeps the display before it can be preempted (>=1).
- BLANK_CYCLES, 24'd250_000, cycles the display is disabled between owners (>=1).

Ports:
- I_sys_clk, input, 1: system clock.
- I_rst_n, input, 1: reset, asynchronous, active-low.
- I_req, input, N_REQ: per-requester display request, level. Held high while the requester wants the display.
- I_disp_data_bus, input, 16*N_REQ: requester k's 4 hex digits in bits [16k+15:16k].
- O_gnt, output, N_REQ: one-hot grant, registered.
- O_owner, output, IDX_W: index of the current or last owner.
- O_disp_en, output, 1: enable to the display driver.
- O_disp_data, output, 16: data to the display driver, registered.
- O_busy, output, 1: high in OWN or BLANK.

Behaviour:
- One clock domain: I_sys_clk. Reset is asynchronous and active-low on I_rst_n. All state is reset asynchronously.
- Reset values:
  - state = IDLE.
  - O_gnt, O_disp_en, O_disp_data and O_busy = 0.
  - O_owner = N_REQ-1, so requester 0 has first priority.
  - Hold and blank counters = 0.
- Reset mid-operation returns to these values immediately; the grant is withdrawn asynchronously.
- State machine IDLE -> OWN -> BLANK -> IDLE:
  - IDLE:
    - O_disp_en = 0.
    - If any I_req bit is high, pick the first requester searching round-robin from O_owner+1 (wrapping at N_REQ-1 -> 0).
    - Next cycle: state OWN, O_gnt one-hot for the winner, O_owner = winner, hold_cnt = 0.
    - Latency from request high to grant: 1 cycle.
    - No request: stay in IDLE.
  - OWN:
    - O_disp_en = 1.
    - Each cycle O_disp_data <= the owner's 16-bit slice, so data changes appear 1 cycle later.
    - hold_cnt increments and saturates at MIN_HOLD.
    - Transition to BLANK if either:
      - (a) the owner's I_req is low, or
      - (b) hold_cnt == MIN_HOLD and any other I_req bit is high (preemption).
    - If (a) and (b) occur together, treat it as (a); the result is identical.
    - A lone requester keeps the display indefinitely.
  - BLANK:
    - O_gnt = 0, O_disp_en = 0, O_disp_data = 0. O_owner is retained.
    - blank_cnt counts from 0 to BLANK_CYCLES-1, then state goes to IDLE. The gap is exactly BLANK_CYCLES cycles.
    - Requests arriving during BLANK are only evaluated in IDLE.
- Round-robin fairness:
  - A preempted owner whose request is still high loses priority to all other pending requesters.
  - It may be regranted in the next IDLE cycle only if no other request is pending.
- Request bits for indices >= N_REQ do not exist. O_gnt never has more than one bit set.
- Width rules:
  - Counters are HOLD_W bits.
  - A MIN_HOLD or BLANK_CYCLES value that does not fit in HOLD_W is a configuration error; an assertion fires at elaboration.

Optional Feature:
- Macro name: DISP_ARB_LOCK_EN.
- Defined:
  - Adds input I_lock (1 bit), sampled only while in OWN.
  - While I_lock is high, preemption (b) is suppressed.
  - Release on request drop (a) still applies.
  - Lets a requester pin the display, e.g. for an error code.
- Undefined: the I_lock port is absent and preemption behaves as above.

Test Plan:
1. Reset → outputs and first grant.
   - Stimulus: assert I_rst_n=0 mid-OWN with MIN_HOLD=8, BLANK_CYCLES=3.
   - Response: O_gnt=0, O_disp_en=0, O_disp_data=0, O_owner=3 immediately.
   - Stimulus: after release, I_req=4'b0101.
   - Response: 1 cycle later O_gnt=4'b0001, O_owner=0.
2. Single owner and release.
   - Stimulus: I_req=4'b0010, data slice 1 = 16'h1234.
   - Response: O_disp_data=16'h1234 one cycle after grant, held beyond 100 cycles.
   - Stimulus: drop I_req[1].
   - Response: next cycle BLANK; O_disp_en=0 for exactly 3 cycles, then IDLE.
3. Preemption and rotation.
   - Stimulus: I_req=4'b1111 held.
   - Response: grants in order 0,1,2,3,0. Each OWN lasts 9 cycles (hold_cnt 0..8). Each gap is 3 cycles.
4. Live data tracking.
   - Stimulus: while owner 2 holds, change slice 2 from 16'hABCD to 16'h00FF.
   - Response: O_disp_data=16'h00FF exactly 1 cycle later. Changes to other slices have no effect.
5. Request during BLANK.
   - Stimulus: I_req[3] rises during the 2nd BLANK cycle after owner 0 drops.
   - Response: grant to 3 occurs 1 cycle after BLANK ends, never earlier.
6. DISP_ARB_LOCK_EN build.
   - Stimulus: owner 0 with I_lock=1 and I_req=4'b0011 held.
   - Response: no preemption for more than 50 cycles.
   - Stimulus: deassert I_lock.
   - Response: BLANK the next cycle (hold already saturated), then grant to 1.
